ili9341_spi_display_model: RTL
==============================

Name: ili9341_spi_display_model

Overview:
- Responder end of the ILI9341 4-wire SPI write interface: a synthesizable display-chip model driven by the display controller.
- Oversamples SPI pins in the system clock domain, assembles bytes and splits them into commands and data using data_commandb.
- Tracks column/page address windows and streams RAMWR pixel words into a framebuffer write port.
- Used as an on-chip loopback target for simulation and FPGA self-test.

Parameters:
- CLK_HZ, 12_000_000, system clock rate; informational only. The bench must keep the clk rate ≥ 4× the sclk rate.
- DISPLAY_WIDTH, 240, number of columns; reset column-window end = DISPLAY_WIDTH-1.
- DISPLAY_HEIGHT, 320, number of pages (rows); reset page-window end = DISPLAY_HEIGHT-1.
- FB_START_ADDRESS, 0, offset added to every framebuffer address.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- spi_csb  in  1  chip select, active low
- spi_clk  in  1  SPI clock, mode 0, MSB first
- spi_mosi  in  1  serial data in
- data_commandb  in  1  1 = data byte, 0 = command byte
- spi_miso  out  1  tied 0 (write-only model)
- fb_wr_ena  out  1  one-cycle pixel write strobe
- fb_wr_addr  out  32  FB_START_ADDRESS + row*DISPLAY_WIDTH + col
- fb_wr_data  out  16  RGB565 pixel value
- cmd_valid  out  1  one-cycle pulse per received command byte
- cmd_byte  out  8  last command byte received
- display_on  out  1  set by DISPON (0x29), cleared by DISPOFF (0x28)
- sleeping  out  1  cleared by SLPOUT (0x11), set by SLPIN (0x10)
- frame_done  out  1  one-cycle pulse, coincident with the write of the last pixel of the window
- protocol_error  out  1  sticky flag

Behaviour:
- Reset (asynchronous, all outputs):
  - fb_wr_ena=0, fb_wr_addr=FB_START_ADDRESS, fb_wr_data=0.
  - cmd_valid=0, cmd_byte=0x00, display_on=0, sleeping=1, frame_done=0, protocol_error=0.
  - Windows: SC=0, EC=DISPLAY_WIDTH-1, SP=0, EP=DISPLAY_HEIGHT-1. col=0, row=0.
- Input sampling:
  - spi_csb, spi_clk, spi_mosi and data_commandb each pass through a 2-flop synchronizer.
  - A third register on sclk provides rising-edge detection.
  - On a detected rising edge with csb low, mosi shifts in and the bit counter increments.
- Byte framing:
  - The 8th bit completes a byte; dc is sampled with that bit.
  - csb high clears the bit counter and discards the partial byte. If the discarded partial byte had bit count ≠ 0, protocol_error is set.
  - The pixel byte phase and command context persist across csb toggles.
- Latency: any output caused by a byte is asserted exactly 4 clk cycles after the first clk edge at which the byte's 8th sclk rise appears at the pin.
- Decoder FSM states: S_IDLE, S_CASET, S_PASET, S_RAMWR, S_IGNORE.
- Command byte (dc=0):
  - Pulses cmd_valid, latches cmd_byte, clears the parameter index and the pixel phase.
  - 0x2A → S_CASET; 0x2B → S_PASET; 0x2C → S_RAMWR, with col←SC and row←SP.
  - 0x00 NOP → no state change.
  - 0x10/0x11/0x28/0x29 update their flags and go to S_IGNORE.
  - All other commands → S_IGNORE.
- S_CASET / S_PASET data:
  - Parameter bytes 0..3 are start[15:8], start[7:0], end[15:8], end[7:0].
  - The window updates after byte 3; further data bytes are ignored.
  - If start > end, or end ≥ DISPLAY_WIDTH (DISPLAY_HEIGHT for PASET), the window is left unchanged and protocol_error is set.
  - Fewer than 4 parameters before the next command leaves the window unchanged.
- S_RAMWR data:
  - Even-phase byte is the pixel high byte; odd-phase byte completes the pixel. On completion, fb_wr_ena=1 for one cycle with the current address and data.
  - After each pixel: col = (col==EC) ? SC : col+1.
  - When the column wraps: row = (row==EP) ? SP : row+1.
  - The write at col==EC and row==EP also pulses frame_done; writing continues, wrapping to (SC,SP).
- S_IGNORE and S_IDLE: data bytes are ignored.
- Address arithmetic is at least 32 bits wide with no truncation.
- Simultaneous events: a csb rise in the same cycle as an 8th-bit edge completes the byte first, then clears the counter.
- Reset mid-byte aborts everything immediately; no fb write occurs.

Test Plan:
- Reset release, no SPI activity → display_on=0, sleeping=1, protocol_error=0, and fb_wr_ena never asserts over 1000 cycles.
- Send cmd 0x11, then cmd 0x29 → two cmd_valid pulses, cmd_byte=0x29, sleeping=0, display_on=1.
- Send cmd 0x2C, then 16-bit data 0xF800, 0x07E0 → writes (addr 0, data 0xF800) and (addr 1, data 0x07E0). Each fb_wr_ena fires 4 cycles after the final sclk rise.
- Set CASET 10..11 and PASET 5..6, RAMWR, then 5 pixels → addresses 1210, 1211, 1450, 1451, 1210. frame_done pulses on the 4th write only.
- Full default frame of 76800 pixels → last address 76799 with frame_done. The next pixel wraps to address 0.
- Three error cases, each with the required response:
  - csb raised after 5 bits → byte discarded and protocol_error=1.
  - CASET 100..50 → window unchanged and protocol_error=1.
  - Async rst asserted mid-RAMWR → outputs return to reset values in the same cycle.

Source files
------------

// File: rtl/ili9341_spi_display_model.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ili9341_spi_display_model                                        |
// | Brief   : ILI9341 4-wire SPI write-side responder that decodes commands,   |
// |           tracks CASET/PASET windows and streams RAMWR pixels to a         |
// |           framebuffer port.                                                |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module ili9341_spi_display_model #(
    parameter int CLK_HZ           = 12_000_000,
    parameter int DISPLAY_WIDTH    = 240,
    parameter int DISPLAY_HEIGHT   = 320,
    parameter int FB_START_ADDRESS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_csb,
    input  logic        spi_clk,
    input  logic        spi_mosi,
    input  logic        data_commandb,
    output logic        spi_miso,
    output logic        fb_wr_ena,
    output logic [31:0] fb_wr_addr,
    output logic [15:0] fb_wr_data,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        display_on,
    output logic        sleeping,
    output logic        frame_done,
    output logic        protocol_error
);

    localparam logic [15:0] c_width16  = 16'(DISPLAY_WIDTH);
    localparam logic [15:0] c_height16 = 16'(DISPLAY_HEIGHT);
    localparam logic [15:0] c_ec_rst   = 16'(DISPLAY_WIDTH - 1);
    localparam logic [15:0] c_ep_rst   = 16'(DISPLAY_HEIGHT - 1);
    localparam logic [31:0] c_width32  = 32'(DISPLAY_WIDTH);
    localparam logic [31:0] c_base32   = 32'(FB_START_ADDRESS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CASET  = 3'd1,
        S_PASET  = 3'd2,
        S_RAMWR  = 3'd3,
        S_IGNORE = 3'd4
    } state_t;

    // The model never drives read data; CLK_HZ carries no timing meaning here.
    generate
        if (CLK_HZ > 0) begin : g_miso
            assign spi_miso = 1'b0;
        end else begin : g_miso_noclk
            assign spi_miso = 1'b0;
        end
    endgenerate

    logic [2:0]  r_csb_s;
    logic [2:0]  r_sclk_s;
    logic [1:0]  r_mosi_s;
    logic [1:0]  r_dc_s;
    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_shreg;
    logic        r_byte_stb;
    logic [7:0]  r_byte;
    logic        r_byte_dc;
    logic        r_frame_err;
    logic        r_b_stb;
    logic [7:0]  r_b_byte;
    logic        r_b_dc;
    logic        r_b_err;

    logic        w_rise;
    logic        w_shift;
    logic        w_last;

    assign w_rise  = r_sclk_s[1] & ~r_sclk_s[2];
    // A rise is still accepted in the cycle csb goes high so a closing 8th bit completes.
    assign w_shift = w_rise & (~r_csb_s[1] | ~r_csb_s[2]);
    assign w_last  = w_shift & (r_bit_cnt == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csb_s     <= 3'b111;
            r_sclk_s    <= 3'b000;
            r_mosi_s    <= 2'b00;
            r_dc_s      <= 2'b00;
            r_bit_cnt   <= 3'd0;
            r_shreg     <= 7'd0;
            r_byte_stb  <= 1'b0;
            r_byte      <= 8'd0;
            r_byte_dc   <= 1'b0;
            r_frame_err <= 1'b0;
            r_b_stb     <= 1'b0;
            r_b_byte    <= 8'd0;
            r_b_dc      <= 1'b0;
            r_b_err     <= 1'b0;
        end else begin
            r_csb_s     <= {r_csb_s[1:0], spi_csb};
            r_sclk_s    <= {r_sclk_s[1:0], spi_clk};
            r_mosi_s    <= {r_mosi_s[0], spi_mosi};
            r_dc_s      <= {r_dc_s[0], data_commandb};
            r_byte_stb  <= w_last;
            r_frame_err <= 1'b0;
            if (w_shift) begin
                r_shreg <= {r_shreg[5:0], r_mosi_s[1]};
            end
            if (w_last) begin
                r_byte    <= {r_shreg, r_mosi_s[1]};
                r_byte_dc <= r_dc_s[1];
            end
            if (r_csb_s[1]) begin
                r_bit_cnt <= 3'd0;
                if (!w_last && (r_bit_cnt != 3'd0 || w_shift)) begin
                    r_frame_err <= 1'b1;
                end
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            r_b_stb  <= r_byte_stb;
            r_b_byte <= r_byte;
            r_b_dc   <= r_byte_dc;
            r_b_err  <= r_frame_err;
        end
    end

    state_t      r_state;
    logic [2:0]  r_param_idx;
    logic [15:0] r_start;
    logic [7:0]  r_end_hi;
    logic        r_pix_phase;
    logic [7:0]  r_pix_hi;
    logic [15:0] r_sc;
    logic [15:0] r_ec;
    logic [15:0] r_sp;
    logic [15:0] r_ep;
    logic [15:0] r_col;
    logic [15:0] r_row;

    logic [15:0] w_new_end;
    logic [15:0] w_limit;
    logic [31:0] w_addr;

    assign w_new_end = {r_end_hi, r_b_byte};
    assign w_limit   = (r_state == S_CASET) ? c_width16 : c_height16;
    assign w_addr    = c_base32 + ({16'd0, r_row} * c_width32) + {16'd0, r_col};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_param_idx    <= 3'd0;
            r_start        <= 16'd0;
            r_end_hi       <= 8'd0;
            r_pix_phase    <= 1'b0;
            r_pix_hi       <= 8'd0;
            r_sc           <= 16'd0;
            r_ec           <= c_ec_rst;
            r_sp           <= 16'd0;
            r_ep           <= c_ep_rst;
            r_col          <= 16'd0;
            r_row          <= 16'd0;
            fb_wr_ena      <= 1'b0;
            fb_wr_addr     <= c_base32;
            fb_wr_data     <= 16'd0;
            cmd_valid      <= 1'b0;
            cmd_byte       <= 8'h00;
            display_on     <= 1'b0;
            sleeping       <= 1'b1;
            frame_done     <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            fb_wr_ena  <= 1'b0;
            cmd_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (r_b_err) begin
                protocol_error <= 1'b1;
            end
            if (r_b_stb && !r_b_dc) begin
                cmd_valid   <= 1'b1;
                cmd_byte    <= r_b_byte;
                r_param_idx <= 3'd0;
                r_pix_phase <= 1'b0;
                case (r_b_byte)
                    8'h2A: r_state <= S_CASET;
                    8'h2B: r_state <= S_PASET;
                    8'h2C: begin
                        r_state <= S_RAMWR;
                        r_col   <= r_sc;
                        r_row   <= r_sp;
                    end
                    8'h00: r_state <= r_state;
                    8'h10: begin sleeping   <= 1'b1; r_state <= S_IGNORE; end
                    8'h11: begin sleeping   <= 1'b0; r_state <= S_IGNORE; end
                    8'h28: begin display_on <= 1'b0; r_state <= S_IGNORE; end
                    8'h29: begin display_on <= 1'b1; r_state <= S_IGNORE; end
                    default: r_state <= S_IGNORE;
                endcase
            end else if (r_b_stb) begin
                case (r_state)
                    S_CASET, S_PASET: begin
                        if (r_param_idx != 3'd4) begin
                            r_param_idx <= r_param_idx + 3'd1;
                        end
                        case (r_param_idx)
                            3'd0: r_start[15:8] <= r_b_byte;
                            3'd1: r_start[7:0]  <= r_b_byte;
                            3'd2: r_end_hi      <= r_b_byte;
                            3'd3: begin
                                if (r_start > w_new_end || w_new_end >= w_limit) begin
                                    protocol_error <= 1'b1;
                                end else if (r_state == S_CASET) begin
                                    r_sc <= r_start;
                                    r_ec <= w_new_end;
                                end else begin
                                    r_sp <= r_start;
                                    r_ep <= w_new_end;
                                end
                            end
                            default: ;
                        endcase
                    end
                    S_RAMWR: begin
                        if (!r_pix_phase) begin
                            r_pix_hi    <= r_b_byte;
                            r_pix_phase <= 1'b1;
                        end else begin
                            r_pix_phase <= 1'b0;
                            fb_wr_ena   <= 1'b1;
                            fb_wr_addr  <= w_addr;
                            fb_wr_data  <= {r_pix_hi, r_b_byte};
                            frame_done  <= (r_col == r_ec) && (r_row == r_ep);
                            if (r_col == r_ec) begin
                                r_col <= r_sc;
                                r_row <= (r_row == r_ep) ? r_sp : r_row + 16'd1;
                            end else begin
                                r_col <= r_col + 16'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
